// File: rtl/vmem_banked_local_if.sv
// Request/response handshake bundle for the banked vector scratchpad.
// The master is the issue stage; the slave is the scratchpad.
interface vmem_banked_local_if #(
  parameter int NUMLANES     = 8,
  parameter int DATAWORDSIZE = 16,
  parameter int AWIDTH       = 14,
  parameter int VCWIDTH      = 32,
  parameter int OFFWIDTH     = 16
);
  logic                             req_valid;
  logic                             req_ready;
  logic [6:0]                       req_op;
  logic [AWIDTH-1:0]                req_base;
  logic [VCWIDTH-1:0]               req_stride;
  logic [NUMLANES*OFFWIDTH-1:0]     req_offset;
  logic [NUMLANES-1:0]              req_mask;
  logic [NUMLANES*DATAWORDSIZE-1:0] req_wdata;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [NUMLANES*DATAWORDSIZE-1:0] rsp_rdata;
  logic [7:0]                       rsp_rounds;

  modport master (
    output req_valid, req_op, req_base, req_stride,
    output req_offset, req_mask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rounds
  );

  modport slave (
    input  req_valid, req_op, req_base, req_stride,
    input  req_offset, req_mask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_rounds
  );
endinterface

// File: rtl/vmem_banked_local.sv
// Word-interleaved banked vector scratchpad; bank conflicts are
// serialised by replaying rounds until every enabled lane is served.
module vmem_banked_local #(
  parameter int NUMLANES     = 8,
  parameter int NUMBANKS     = 8,
  parameter int DATAWORDSIZE = 16,
  parameter int MEMDEPTH     = 2048,
  parameter int VCWIDTH      = 32,
  parameter int OFFWIDTH     = 16
) (
  input logic                clk,
  input logic                reset,
  vmem_banked_local_if.slave bus
);
  localparam int LOGBANKS    = $clog2(NUMBANKS);
  localparam int LOGMEMDEPTH = $clog2(MEMDEPTH);
  localparam int AWIDTH      = LOGBANKS + LOGMEMDEPTH;
  localparam int DW          = DATAWORDSIZE;

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, RESP
  } state_t;

  state_t state_q, state_d;

  logic                   we_q;
  logic [AWIDTH-1:0]      addr_q  [NUMLANES];
  logic [DW-1:0]          wdata_q [NUMLANES];
  logic [DW-1:0]          rdata_q [NUMLANES];
  logic [AWIDTH-1:0]      lane_addr [NUMLANES];
  logic [NUMLANES-1:0]    pend_q;
  logic [NUMLANES-1:0]    grant;
  logic [NUMLANES-1:0]    rlane_q;
  logic [7:0]             rounds_q;
  logic [NUMBANKS-1:0]    bk_en;
  logic [LOGMEMDEPTH-1:0] bk_row   [NUMBANKS];
  logic [DW-1:0]          bk_wdata [NUMBANKS];
  logic [DW-1:0]          bk_rd    [NUMBANKS];
  logic [DW-1:0]          mem [NUMBANKS][MEMDEPTH];
  logic                   accept;
  logic                   op_mem;
  logic                   op_we;
  logic [2:0]             unused_op;

  assign op_mem    = bus.req_op[6];
  assign op_we     = bus.req_op[0];
  assign unused_op = bus.req_op[3:1];
  assign accept    = bus.req_valid && bus.req_ready;

  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      case (bus.req_op[5:4])
        2'b00:   lane_addr[i] = bus.req_base + AWIDTH'(i);
        2'b01:   lane_addr[i] = bus.req_base
                   + AWIDTH'(bus.req_stride * VCWIDTH'(i));
        default: lane_addr[i] = bus.req_base
                   + AWIDTH'(bus.req_offset[i*OFFWIDTH +: OFFWIDTH]);
      endcase
    end
  end

  // Lowest pending lane wins its bank; loads to the same word ride along.
  always_comb begin
    logic [NUMBANKS-1:0] taken;
    logic [LOGBANKS-1:0] bk;
    grant = '0;
    taken = '0;
    bk    = '0;
    for (int b = 0; b < NUMBANKS; b++) begin
      bk_row[b]   = '0;
      bk_wdata[b] = '0;
    end
    for (int i = 0; i < NUMLANES; i++) begin
      bk = addr_q[i][LOGBANKS-1:0];
      if (pend_q[i]) begin
        if (!taken[bk]) begin
          taken[bk]    = 1'b1;
          grant[i]     = 1'b1;
          bk_row[bk]   = addr_q[i][AWIDTH-1:LOGBANKS];
          bk_wdata[bk] = wdata_q[i];
        end else if (!we_q &&
                     bk_row[bk] == addr_q[i][AWIDTH-1:LOGBANKS]) begin
          grant[i] = 1'b1;
        end
      end
    end
    bk_en = (state_q == ISSUE && !reset) ? taken : '0;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUMBANKS; b++) begin
      if (bk_en[b]) begin
        if (we_q) mem[b][bk_row[b]] <= bk_wdata[b];
        else      bk_rd[b] <= mem[b][bk_row[b]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q <= op_we;
      for (int i = 0; i < NUMLANES; i++) begin
        addr_q[i]  <= lane_addr[i];
        wdata_q[i] <= bus.req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      rlane_q  <= '0;
      rounds_q <= '0;
      for (int i = 0; i < NUMLANES; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rlane_q <= (state_q == ISSUE && !we_q) ? grant : '0;
      // Read data lands one cycle after its round, in the next round or DRAIN.
      for (int i = 0; i < NUMLANES; i++) begin
        if (rlane_q[i]) rdata_q[i] <= bk_rd[addr_q[i][LOGBANKS-1:0]];
      end
      if (accept) begin
        pend_q   <= op_mem ? bus.req_mask : '0;
        rounds_q <= '0;
        for (int i = 0; i < NUMLANES; i++) rdata_q[i] <= '0;
      end else if (state_q == ISSUE) begin
        pend_q <= pend_q & ~grant;
        if (rounds_q != 8'hff) rounds_q <= rounds_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (op_mem && |bus.req_mask) ? ISSUE : DRAIN;
      end
      ISSUE: begin
        if ((pend_q & ~grant) == '0) state_d = DRAIN;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_rounds = rounds_q;
    bus.rsp_rdata  = '0;
    for (int i = 0; i < NUMLANES; i++) begin
      bus.rsp_rdata[i*DW +: DW] = rdata_q[i];
    end
  end
endmodule

// File: tb/tb_vmem_banked_local.sv
// Directed bench for the banked vector scratchpad: unit, strided,
// indexed, broadcast, masking, back-pressure, wrap and mid-op reset.
module tb_vmem_banked_local;
  localparam logic [6:0] UNIT_LD = 7'h40;
  localparam logic [6:0] UNIT_ST = 7'h41;
  localparam logic [6:0] STR_LD  = 7'h50;
  localparam logic [6:0] STR_ST  = 7'h51;
  localparam logic [6:0] IDX_LD  = 7'h60;
  localparam logic [6:0] IDX_ST  = 7'h61;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  int lat;
  logic [127:0] rd;
  logic [127:0] e;
  logic [127:0] wd;
  logic [127:0] off;
  logic [7:0] rn;

  always #5 clk = ~clk;

  vmem_banked_local_if bus ();

  vmem_banked_local dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_req(
    input  logic [6:0]   op,
    input  logic [13:0]  base,
    input  logic [31:0]  stride,
    input  logic [127:0] offs,
    input  logic [7:0]   mask,
    input  logic [127:0] wdat,
    output int           l,
    output logic [127:0] r,
    output logic [7:0]   n
  );
    @(negedge clk);
    bus.req_op     = op;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_offset = offs;
    bus.req_mask   = mask;
    bus.req_wdata  = wdat;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_base   = 14'h1555;
    bus.req_stride = 32'h3;
    bus.req_offset = '1;
    bus.req_mask   = 8'h5a;
    bus.req_wdata  = '1;
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!bus.rsp_valid && l < 40);
    r = bus.rsp_rdata;
    n = bus.rsp_rounds;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.req_valid = 0; bus.rsp_ready = 0; bus.req_op = 0;
    bus.req_base = 0; bus.req_stride = 0; bus.req_offset = 0;
    bus.req_mask = 0; bus.req_wdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_run++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0",
               bus.req_ready, bus.rsp_valid);
    end
    n_run++;
    if (bus.rsp_rdata !== '0 || bus.rsp_rounds !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_rsp got %h/%0d want 0/0",
               bus.rsp_rdata, bus.rsp_rounds);
    end
  endtask

  task automatic test_unit;
    for (int i = 0; i < 8; i++) wd[i*16 +: 16] = 16'h100 + 16'(i);
    do_req(UNIT_ST, 0, 0, 0, 8'hff, wd, lat, rd, rn);
    n_run++;
    if (rn !== 8'd1 || lat !== 2 || rd !== '0) begin
      n_fail++;
      $display("FAIL unit_st got rounds=%0d lat=%0d rd=%h want 1 2 0",
               rn, lat, rd);
    end
    do_req(UNIT_LD, 0, 0, 0, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== wd) begin
      n_fail++;
      $display("FAIL unit_ld_data got %h want %h", rd, wd);
    end
    n_run++;
    if (rn !== 8'd1 || lat !== 2) begin
      n_fail++;
      $display("FAIL unit_ld_timing got rounds=%0d lat=%0d want 1 2",
               rn, lat);
    end
  endtask

  task automatic test_strided;
    for (int i = 0; i < 8; i++) wd[i*16 +: 16] = 16'h200 + 16'(i);
    do_req(STR_ST, 0, 8, 0, 8'hff, wd, lat, rd, rn);
    n_run++;
    if (rn !== 8'd8 || lat !== 9) begin
      n_fail++;
      $display("FAIL str_st got rounds=%0d lat=%0d want 8 9", rn, lat);
    end
    do_req(STR_LD, 0, 8, 0, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== wd) begin
      n_fail++;
      $display("FAIL str_ld_data got %h want %h", rd, wd);
    end
    n_run++;
    if (rn !== 8'd8 || lat !== 9) begin
      n_fail++;
      $display("FAIL str_ld_timing got rounds=%0d lat=%0d want 8 9",
               rn, lat);
    end
  endtask

  task automatic test_broadcast;
    for (int i = 0; i < 8; i++) off[i*16 +: 16] = 16'd5;
    for (int i = 0; i < 8; i++) e[i*16 +: 16] = 16'h201;
    do_req(IDX_LD, 3, 0, off, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== e || rn !== 8'd1 || lat !== 2) begin
      n_fail++;
      $display("FAIL bcast_ld got %h r=%0d l=%0d want %h 1 2",
               rd, rn, lat, e);
    end
    for (int i = 0; i < 8; i++) wd[i*16 +: 16] = 16'h300 + 16'(i);
    do_req(IDX_ST, 3, 0, off, 8'hff, wd, lat, rd, rn);
    n_run++;
    if (rn !== 8'd8 || lat !== 9) begin
      n_fail++;
      $display("FAIL idx_st got rounds=%0d lat=%0d want 8 9", rn, lat);
    end
    do_req(UNIT_LD, 8, 0, 0, 8'h01, 0, lat, rd, rn);
    n_run++;
    if (rd !== 128'h307) begin
      n_fail++;
      $display("FAIL idx_st_last got %h want 307", rd);
    end
  endtask

  task automatic test_mask;
    e = '0;
    e[15:0]  = 16'h200;
    e[47:32] = 16'h102;
    do_req(UNIT_LD, 0, 0, 0, 8'h05, 0, lat, rd, rn);
    n_run++;
    if (rd !== e || rn !== 8'd1) begin
      n_fail++;
      $display("FAIL mask05 got %h r=%0d want %h 1", rd, rn, e);
    end
    do_req(UNIT_LD, 0, 0, 0, 8'h00, 0, lat, rd, rn);
    n_run++;
    if (rd !== '0 || rn !== 8'd0 || lat !== 1) begin
      n_fail++;
      $display("FAIL mask0 got %h r=%0d l=%0d want 0 0 1", rd, rn, lat);
    end
    do_req(7'h00, 0, 0, 0, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== '0 || rn !== 8'd0 || lat !== 1) begin
      n_fail++;
      $display("FAIL nomemop got %h r=%0d l=%0d want 0 0 1", rd, rn, lat);
    end
  endtask

  task automatic test_backpressure;
    int k;
    for (int i = 0; i < 8; i++) e[i*16 +: 16] = 16'h100 + 16'(i);
    e[15:0] = 16'h200;
    @(negedge clk);
    bus.req_op = UNIT_LD; bus.req_base = 0; bus.req_mask = 8'hff;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_mask = 8'h00;
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      n_run++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata} !== {2'b01, e}) begin
        n_fail++;
        $display("FAIL hold c=%0d got rdy=%b vld=%b %h want 0 1 %h",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, e);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    n_run++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rsp_only got rdy=%b vld=%b want 1 0",
               bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    n_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rounds !== 8'd0 ||
        bus.rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL late_req got vld=%b r=%0d %h want 1 0 0",
               bus.rsp_valid, bus.rsp_rounds, bus.rsp_rdata);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) wd[i*16 +: 16] = 16'h400 + 16'(i);
    do_req(STR_ST, 0, 32'hffff_ffff, 0, 8'hff, wd, lat, rd, rn);
    n_run++;
    if (rn !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_st got rounds=%0d want 1", rn);
    end
    do_req(STR_LD, 0, 32'hffff_ffff, 0, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== wd || rn !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_ld got %h r=%0d want %h 1", rd, rn, wd);
    end
    for (int i = 0; i < 8; i++) off[i*16 +: 16] = 16'(16384 - i);
    do_req(IDX_LD, 0, 0, off, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== wd) begin
      n_fail++;
      $display("FAIL wrap_idx got %h want %h", rd, wd);
    end
  endtask

  task automatic test_reset_mid;
    do_req(STR_ST, 64, 8, 0, 8'hff, 0, lat, rd, rn);
    for (int i = 0; i < 8; i++) wd[i*16 +: 16] = 16'h500 + 16'(i);
    @(negedge clk);
    bus.req_op = STR_ST; bus.req_base = 64; bus.req_stride = 8;
    bus.req_mask = 8'hff; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_run++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10 ||
        bus.rsp_rounds !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset got rdy=%b vld=%b r=%0d want 1 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rounds);
    end
    @(negedge clk);
    reset = 1'b0;
    e = '0;
    for (int i = 0; i < 4; i++) e[i*16 +: 16] = 16'h500 + 16'(i);
    do_req(STR_LD, 64, 8, 0, 8'hff, 0, lat, rd, rn);
    n_run++;
    if (rd !== e || rn !== 8'd8) begin
      n_fail++;
      $display("FAIL mid_partial got %h r=%0d want %h 8", rd, rn, e);
    end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_strided();
    test_broadcast();
    test_mask();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
